// File: rtl/fofb_readout_sequencer.sv
// Sweeps the FOFB DSP readout over bpmCount BPMs, subtracts per-BPM setpoints with
// 32-bit saturation and streams {Yerr, Xerr} beats through a 4-deep AXI-stream buffer.
module fofb_readout_sequencer #(
  parameter int FOFB_INDEX_WIDTH = 9,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        sysClk,
  input  logic                        sysResetN,
  input  logic                        readoutValid,
  input  logic [FOFB_INDEX_WIDTH:0]   bpmCount,
  input  logic                        spWrStrobe,
  input  logic [FOFB_INDEX_WIDTH-1:0] spWrAddr,
  input  logic [63:0]                 spWrData,
  output logic [FOFB_INDEX_WIDTH-1:0] fofbDSPreadoutAddress,
  input  logic [31:0]                 fofbDSPreadoutX,
  input  logic [31:0]                 fofbDSPreadoutY,
  input  logic [31:0]                 fofbDSPreadoutS,
  output logic                        M_TVALID,
  input  logic                        M_TREADY,
  output logic [63:0]                 M_TDATA,
  output logic [FOFB_INDEX_WIDTH:0]   M_TUSER,
  output logic                        M_TLAST,
  output logic                        busy,
  output logic [15:0]                 overrunCount,
  output logic [15:0]                 lastSweepCycles
);

  localparam int AW = FOFB_INDEX_WIDTH;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = AW + 66;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} seqStateT;

  seqStateT stateReg, stateNext;

  logic          rvPrevReg, armedReg, fellReg;
  logic [AW-1:0] addrReg, inflightAddrReg;
  logic [AW:0]   bpmCountReg;
  logic          inflightReg, inflightLastReg;
  logic [OW-1:0] occReg;
  logic [PW-1:0] wrPtrReg, rdPtrReg;
  logic [15:0]   cycleCntReg, overrunReg, lastSweepReg;

  logic          startEdge, fallEdge, issue, sweepDone, isLast, canIssue, pop, missing;
  logic [OW:0]   pending;
  logic [EW-1:0] fifoMem [FIFO_DEPTH];
  logic [EW-1:0] headEntry, wrEntry;
  logic [63:0]   spRam [0:(1 << AW) - 1];
  logic [63:0]   spRdReg;
  logic [31:0]   upVal  [2];
  logic [31:0]   errVal [2];

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // armedReg blocks a level that was already high when reset released
  assign startEdge = readoutValid & ~rvPrevReg & armedReg;
  assign fallEdge  = ~readoutValid & rvPrevReg;
  assign pending   = {1'b0, occReg} + {{OW{1'b0}}, inflightReg};
  assign canIssue  = pending < (OW + 1)'(FIFO_DEPTH);
  assign isLast    = ({1'b0, addrReg} == bpmCountReg - (AW + 1)'(1));
  assign pop       = M_TVALID & M_TREADY;

  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) stateReg <= IDLE;
    else            stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    issue     = 1'b0;
    sweepDone = 1'b0;
    case (stateReg)
      IDLE: if (startEdge && bpmCount != '0) stateNext = FETCH;
      FETCH: begin
        if (canIssue) begin
          issue = 1'b1;
          if (isLast) stateNext = DRAIN;
        end
      end
      DRAIN: begin
        // leave as soon as the final beat is accepted, not a cycle later
        if (!inflightReg && (occReg == '0 || (occReg == OW'(1) && pop))) begin
          stateNext = IDLE;
          sweepDone = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) begin
      rvPrevReg       <= 1'b0;
      armedReg        <= 1'b0;
      fellReg         <= 1'b0;
      addrReg         <= '0;
      bpmCountReg     <= '0;
      inflightReg     <= 1'b0;
      inflightAddrReg <= '0;
      inflightLastReg <= 1'b0;
      occReg          <= '0;
      wrPtrReg        <= '0;
      rdPtrReg        <= '0;
      cycleCntReg     <= '0;
      overrunReg      <= '0;
      lastSweepReg    <= '0;
    end else begin
      rvPrevReg   <= readoutValid;
      armedReg    <= armedReg | ~readoutValid;
      inflightReg <= issue;
      if (issue) begin
        inflightAddrReg <= addrReg;
        inflightLastReg <= isLast;
        if (!isLast) addrReg <= addrReg + AW'(1);
      end
      if (inflightReg) wrPtrReg <= wrPtrReg + PW'(1);
      if (pop)         rdPtrReg <= rdPtrReg + PW'(1);
      occReg <= occReg + OW'(inflightReg) - OW'(pop);
      if (stateReg == IDLE) begin
        if (startEdge) begin
          bpmCountReg <= bpmCount;
          addrReg     <= '0;
          cycleCntReg <= '0;
          fellReg     <= 1'b0;
          if (bpmCount == '0) lastSweepReg <= '0;
        end
      end else begin
        cycleCntReg <= satInc(cycleCntReg);
        if (startEdge || (fallEdge && !fellReg)) overrunReg <= satInc(overrunReg);
        if (fallEdge) fellReg <= 1'b1;
      end
      if (sweepDone) lastSweepReg <= satInc(cycleCntReg);
    end
  end

  // Read-first setpoint RAM, read in lockstep with the upstream address
  always_ff @(posedge sysClk) begin
    if (spWrStrobe) spRam[spWrAddr] <= spWrData;
    spRdReg <= spRam[addrReg];
  end

  assign upVal[0] = fofbDSPreadoutX;
  assign upVal[1] = fofbDSPreadoutY;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gLane
      logic [32:0] diff;
      assign diff = {upVal[gi][31], upVal[gi]} - {spRdReg[32*gi+31], spRdReg[32*gi +: 32]};
      assign errVal[gi] = (diff[32] != diff[31]) ? {diff[32], {31{~diff[32]}}} : diff[31:0];
    end
  endgenerate

  assign missing = (fofbDSPreadoutS == 32'd0);
  assign wrEntry = {inflightLastReg, inflightAddrReg, missing, errVal[1], errVal[0]};

  always_ff @(posedge sysClk) begin
    if (inflightReg) fifoMem[wrPtrReg] <= wrEntry;
  end

  assign headEntry             = fifoMem[rdPtrReg];
  assign M_TVALID              = (occReg != '0);
  assign M_TDATA               = M_TVALID ? headEntry[63:0] : '0;
  assign M_TUSER               = M_TVALID ? headEntry[64 +: AW + 1] : '0;
  assign M_TLAST               = M_TVALID & headEntry[EW-1];
  assign fofbDSPreadoutAddress = addrReg;
  assign busy                  = (stateReg != IDLE);
  assign overrunCount          = overrunReg;
  assign lastSweepCycles       = lastSweepReg;

endmodule
